// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encoding,
// controller states and the cycle-counter width helper.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Counter must hold the larger of the two latencies.
  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int mx;
    mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one op.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_b_safe;
  logic [31:0] quo;
  logic [31:0] rem;

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed division runs on magnitudes; |0x80000000| fits as unsigned, so the
  // 0x80000000 / -1 overflow case falls out as quotient 0x80000000, remainder 0.
  assign signed_div = (op == OP_DIV);
  assign rs_neg     = signed_div & rs[31];
  assign rt_neg     = signed_div & rt[31];
  assign div_a      = rs_neg ? -rs : rs;
  assign div_b      = rt_neg ? -rt : rt;
  assign div_b_safe = (div_b == 32'd0) ? 32'd1 : div_b;
  assign quo        = div_a / div_b_safe;
  assign rem        = div_a % div_b_safe;

  assign div_by_zero = is_div(op) && (rt == 32'd0);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo = (rs_neg ^ rt_neg) ? -quo : quo;
        res_hi = rs_neg ? -rem : rem;
      end
      OP_DIVU: begin
        res_lo = quo;
        res_hi = rem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage MDU sequencer: fixed-latency mult/div, HI/LO ownership, mf read mux
// and the D-stage stall request.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        mdu_use_D,
  output logic        busy,
  output logic        stall_D,
  output logic        mf_E,
  output logic [31:0] mdu_out,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_d, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;
  logic        start_E;
  logic        mt_E;

  mdu_arith u_arith (
    .op          (mdu_op_E),
    .rs          (rs_E),
    .rt          (rt_E),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  assign start_E = is_arith(mdu_op_E);
  assign mt_E    = (mdu_op_E == OP_MTHI) || (mdu_op_E == OP_MTLO);
  assign busy    = (state_q == BUSY);
  assign stall_D = mdu_use_D & (busy | start_E);
  assign mf_E    = (mdu_op_E == OP_MFHI) || (mdu_op_E == OP_MFLO);

  always_comb begin
    mdu_out = 32'd0;
    if (mdu_op_E == OP_MFHI)      mdu_out = hi_q;
    else if (mdu_op_E == OP_MFLO) mdu_out = lo_q;
  end

  // A divide by zero re-commits the current HI/LO, so the result path stays uniform.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (start_E) begin
          pend_hi_d = div_by_zero ? hi_q : res_hi;
          pend_lo_d = div_by_zero ? lo_q : res_lo;
          cnt_d     = is_div(mdu_op_E) ? DIV_LOAD : MULT_LOAD;
          state_d   = BUSY;
        end else if (mdu_op_E == OP_MTHI) begin
          hi_d = rs_E;
        end else if (mdu_op_E == OP_MTLO) begin
          lo_d = rs_E;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // The hazard unit should make this unreachable; the op itself is dropped.
  always_ff @(posedge clk) begin
    if (reset && busy) begin
      assert (!(start_E || mt_E))
        else $error("mdu_ctrl: MDU op 0x%0h issued while busy", mdu_op_E);
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: default latencies plus a 1/1-cycle instance
// driven by the same stimulus.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        use_d;

  logic        busy, stall, mf;
  logic [31:0] out, hi, lo;
  logic        busy1, stall1, mf1;
  logic [31:0] out1, hi1, lo1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .mdu_op_E(op), .rs_E(rs), .rt_E(rt), .mdu_use_D(use_d),
    .busy(busy), .stall_D(stall), .mf_E(mf), .mdu_out(out), .hi_q(hi), .lo_q(lo)
  );

  mdu_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .mdu_op_E(op), .rs_E(rs), .rt_E(rt), .mdu_use_D(use_d),
    .busy(busy1), .stall_D(stall1), .mf_E(mf1), .mdu_out(out1), .hi_q(hi1), .lo_q(lo1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one arith op in cycle 0 and follow it through both instances.
  task automatic run_op(input logic [3:0] op_v, input logic [31:0] rs_v, input logic [31:0] rt_v,
                        input int n, input logic [31:0] new_hi, input logic [31:0] new_lo,
                        input string tag);
    op = op_v;
    rs = rs_v;
    rt = rt_v;
    tick();
    op = OP_NONE;
    for (int i = 1; i <= n; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (i == 1) check({tag, "_busy1"}, 32'(busy1), 32'd1);
      if (i == 2) begin
        check({tag, "_busy1_done"}, 32'(busy1), 32'd0);
        check({tag, "_hi1"}, hi1, new_hi);
        check({tag, "_lo1"}, lo1, new_lo);
      end
      if (i == n) begin
        check({tag, "_hi_held"}, hi, m_hi);
        check({tag, "_lo_held"}, lo, m_lo);
      end
      tick();
    end
    m_hi = new_hi;
    m_lo = new_lo;
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    reset = 1'b0;
    op    = OP_NONE;
    rs    = 32'd0;
    rt    = 32'd0;
    use_d = 1'b1;
    #3;
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi",    hi,         32'd0);
    check("rst_lo",    lo,         32'd0);
    check("rst_mf",    32'(mf),    32'd0);
    check("rst_out",   out,        32'd0);
    #4;
    reset = 1'b1;
    use_d = 1'b0;
    tick();

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(OP_DIVU,  32'd7,         32'd2, 10, 32'd1,        32'd3,        "divu");

    op = OP_MTHI;
    rs = 32'h0000_1234;
    tick();
    op = OP_NONE;
    m_hi = 32'h0000_1234;
    check("mthi_hi", hi, m_hi);
    check("mthi_lo", lo, m_lo);

    run_op(OP_DIV, 32'd55, 32'd0, 10, 32'h0000_1234, 32'd3, "div_zero");

    op = OP_MFHI;
    #1;
    check("mfhi_mf",  32'(mf), 32'd1);
    check("mfhi_out", out,     32'h0000_1234);
    op = OP_MFLO;
    #1;
    check("mflo_mf",  32'(mf), 32'd1);
    check("mflo_out", out,     32'd3);
    op = OP_NONE;
    #1;
    check("none_mf",  32'(mf), 32'd0);
    check("none_out", out,     32'd0);
    tick();

    // Stall with a D-stage MDU op throughout: 100 / 7 = 14 r 2.
    use_d = 1'b1;
    op = OP_DIV;
    rs = 32'd100;
    rt = 32'd7;
    #1;
    check("stall_c0", 32'(stall), 32'd1);
    tick();
    op = OP_NONE;
    for (int i = 1; i <= 10; i++) begin
      check("stall_busy", 32'(stall), 32'd1);
      tick();
    end
    check("stall_c11", 32'(stall), 32'd0);
    m_hi = 32'd2;
    m_lo = 32'd14;
    check("stall_div_hi", hi, m_hi);
    check("stall_div_lo", lo, m_lo);

    // No D-stage MDU op: never stall. 100 / 9 = 11 r 1.
    use_d = 1'b0;
    op = OP_DIVU;
    rt = 32'd9;
    #1;
    check("nostall_c0", 32'(stall), 32'd0);
    tick();
    op = OP_NONE;
    for (int i = 1; i <= 10; i++) begin
      check("nostall_busy", 32'(stall), 32'd0);
      tick();
    end
    m_hi = 32'd1;
    m_lo = 32'd11;
    check("nostall_hi", hi, m_hi);
    check("nostall_lo", lo, m_lo);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div_ovf");
    m_hi = 32'hDEAD_0001;
    op = OP_MTHI;
    rs = m_hi;
    tick();
    op = OP_NONE;
    check("pre_rst_hi", hi, m_hi);

    // Reset in cycle 3 of a MULT, away from any clock edge.
    op = OP_MULT;
    rs = 32'd5;
    rt = 32'd7;
    tick();
    op = OP_NONE;
    tick();
    tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("midrst_busy",  32'(busy),  32'd0);
    check("midrst_hi",    hi,         m_hi);
    check("midrst_lo",    lo,         m_lo);
    check("midrst_hi1",   hi1,        32'd0);
    #2;
    reset = 1'b1;
    tick();
    run_op(OP_MULT, 32'd5, 32'd7, 5, 32'd0, 32'd35, "mult_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
